control_unit: RTL and testbench

- Single-cycle RV32I-subset processor top level: PC, instruction ROM, 32x32 register file, immediate generator, ALU, data RAM and main/ALU decode.
- Runs a fixed built-in program and exposes the register-file write-back value on `wr2` for observation.
- Top of the datapath. No external memory or bus interfaces.

---
 rtl/control_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_control_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Brief    : Single-cycle RV32I-subset core running a fixed built-in program.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit #(
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] wr2
);

   localparam int c_IW = $clog2(IMEM_DEPTH);
   localparam int c_DW = $clog2(DMEM_DEPTH);

   localparam logic [31:0] c_NOP       = 32'h0000_0013;
   localparam int          c_PROG_LEN  = 9;
   localparam logic [31:0] c_PROG [0:c_PROG_LEN-1] = '{
      32'h0050_0093,   // addi x1,x0,5
      32'h0030_0113,   // addi x2,x0,3
      32'h0020_81B3,   // add  x3,x1,x2
      32'h4020_8233,   // sub  x4,x1,x2
      32'h0030_2023,   // sw   x3,0(x0)
      32'h0000_2283,   // lw   x5,0(x0)
      32'h0020_F333,   // and  x6,x1,x2
      32'h0020_E3B3,   // or   x7,x1,x2
      32'h0000_0063    // beq  x0,x0,0
   };

   localparam logic [6:0] c_OP_R    = 7'b0110011;
   localparam logic [6:0] c_OP_I    = 7'b0010011;
   localparam logic [6:0] c_OP_LW   = 7'b0000011;
   localparam logic [6:0] c_OP_SW   = 7'b0100011;
   localparam logic [6:0] c_OP_BR   = 7'b1100011;
   localparam logic [6:0] c_OP_JAL  = 7'b1101111;

   localparam logic [2:0] c_ALU_ADD = 3'd0;
   localparam logic [2:0] c_ALU_SUB = 3'd1;
   localparam logic [2:0] c_ALU_AND = 3'd2;
   localparam logic [2:0] c_ALU_OR  = 3'd3;
   localparam logic [2:0] c_ALU_XOR = 3'd4;
   localparam logic [2:0] c_ALU_SLT = 3'd5;
   localparam logic [2:0] c_ALU_SLL = 3'd6;
   localparam logic [2:0] c_ALU_SRL = 3'd7;

   logic [31:0] r_pc;
   logic [31:0] r_regs [0:31];
   logic [31:0] r_dmem [0:DMEM_DEPTH-1];

   logic [31:0] w_fetch_idx;
   logic [31:0] w_instr;
   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_j;
   logic [31:0] w_rs1_data;
   logic [31:0] w_rs2_data;

   logic        w_valid;
   logic        w_reg_we;
   logic        w_mem_we;
   logic        w_is_load;
   logic        w_is_jal;
   logic        w_is_branch;
   logic        w_br_ne;
   logic [2:0]  w_alu_op;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_res;
   logic [c_DW-1:0] w_dmem_idx;
   logic [31:0] w_dmem_rdata;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_next;
   logic        w_br_taken;
   logic [31:0] w_wb_data;

   // ---------------------------------------------------------------- fetch
   assign w_fetch_idx = 32'(r_pc[c_IW+1:2]);

   always_comb begin
      w_instr = c_NOP;
      if (w_fetch_idx < 32'(c_PROG_LEN)) begin
         w_instr = c_PROG[w_fetch_idx[3:0]];
      end
   end

   assign w_opcode = w_instr[6:0];
   assign w_rd     = w_instr[11:7];
   assign w_funct3 = w_instr[14:12];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];
   assign w_funct7 = w_instr[31:25];

   assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
   assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
   assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                     w_instr[30:25], w_instr[11:8], 1'b0};
   assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                     w_instr[20], w_instr[30:21], 1'b0};

   // Flop-based register file: same-cycle reads see the pre-write value.
   assign w_rs1_data = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
   assign w_rs2_data = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

   // --------------------------------------------------------------- decode
   always_comb begin
      w_valid     = 1'b0;
      w_reg_we    = 1'b0;
      w_mem_we    = 1'b0;
      w_is_load   = 1'b0;
      w_is_jal    = 1'b0;
      w_is_branch = 1'b0;
      w_br_ne     = 1'b0;
      w_alu_op    = c_ALU_ADD;
      w_alu_b     = w_rs2_data;
      case (w_opcode)
         c_OP_R: begin
            w_valid  = 1'b1;
            w_reg_we = 1'b1;
            case ({w_funct7, w_funct3})
               {7'h00, 3'b000}: w_alu_op = c_ALU_ADD;
               {7'h20, 3'b000}: w_alu_op = c_ALU_SUB;
               {7'h00, 3'b111}: w_alu_op = c_ALU_AND;
               {7'h00, 3'b110}: w_alu_op = c_ALU_OR;
               {7'h00, 3'b100}: w_alu_op = c_ALU_XOR;
               {7'h00, 3'b010}: w_alu_op = c_ALU_SLT;
               {7'h00, 3'b001}: w_alu_op = c_ALU_SLL;
               {7'h00, 3'b101}: w_alu_op = c_ALU_SRL;
               default: begin
                  w_valid  = 1'b0;
                  w_reg_we = 1'b0;
               end
            endcase
         end
         c_OP_I: begin
            w_valid  = 1'b1;
            w_reg_we = 1'b1;
            w_alu_b  = w_imm_i;
            case (w_funct3)
               3'b000:  w_alu_op = c_ALU_ADD;
               3'b111:  w_alu_op = c_ALU_AND;
               3'b110:  w_alu_op = c_ALU_OR;
               3'b100:  w_alu_op = c_ALU_XOR;
               3'b010:  w_alu_op = c_ALU_SLT;
               default: begin
                  w_valid  = 1'b0;
                  w_reg_we = 1'b0;
               end
            endcase
         end
         c_OP_LW: begin
            if (w_funct3 == 3'b010) begin
               w_valid   = 1'b1;
               w_reg_we  = 1'b1;
               w_is_load = 1'b1;
               w_alu_b   = w_imm_i;
            end
         end
         c_OP_SW: begin
            if (w_funct3 == 3'b010) begin
               w_valid  = 1'b1;
               w_mem_we = 1'b1;
               w_alu_b  = w_imm_s;
            end
         end
         c_OP_BR: begin
            if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
               w_valid     = 1'b1;
               w_is_branch = 1'b1;
               w_br_ne     = w_funct3[0];
               w_alu_op    = c_ALU_SUB;
            end
         end
         c_OP_JAL: begin
            w_valid  = 1'b1;
            w_reg_we = 1'b1;
            w_is_jal = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------ ALU
   always_comb begin
      w_alu_res = 32'd0;
      case (w_alu_op)
         c_ALU_ADD: w_alu_res = w_rs1_data + w_alu_b;
         c_ALU_SUB: w_alu_res = w_rs1_data - w_alu_b;
         c_ALU_AND: w_alu_res = w_rs1_data & w_alu_b;
         c_ALU_OR:  w_alu_res = w_rs1_data | w_alu_b;
         c_ALU_XOR: w_alu_res = w_rs1_data ^ w_alu_b;
         c_ALU_SLT: w_alu_res = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
         c_ALU_SLL: w_alu_res = w_rs1_data << w_alu_b[4:0];
         c_ALU_SRL: w_alu_res = w_rs1_data >> w_alu_b[4:0];
         default:   w_alu_res = 32'd0;
      endcase
   end

   // ------------------------------------------------- memory / next PC / WB
   assign w_dmem_idx   = w_alu_res[c_DW+1:2];
   assign w_dmem_rdata = r_dmem[w_dmem_idx];

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_taken = w_is_branch & ((w_alu_res == 32'd0) ^ w_br_ne);

   always_comb begin
      w_pc_next = w_pc_plus4;
      if (w_is_jal) begin
         w_pc_next = r_pc + w_imm_j;
      end else if (w_br_taken) begin
         w_pc_next = r_pc + w_imm_b;
      end
   end

   always_comb begin
      w_wb_data = w_alu_res;
      if (!w_valid) begin
         w_wb_data = 32'd0;
      end else if (w_is_load) begin
         w_wb_data = w_dmem_rdata;
      end else if (w_is_jal) begin
         w_wb_data = w_pc_plus4;
      end
   end

   assign wr2 = reset ? 32'd0 : w_wb_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
         for (int j = 0; j < DMEM_DEPTH; j++) begin
            r_dmem[j] <= 32'd0;
         end
      end else begin
         r_pc <= w_pc_next;
         if (w_reg_we && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_wb_data;
         end
         if (w_mem_we) begin
            r_dmem[w_dmem_idx] <= w_rs2_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Brief    : Scoreboard bench for control_unit: program trace, state, resets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

   logic        clk;
   logic        reset;
   logic [31:0] wr2;

   int          n_cmp;
   int          n_err;
   logic [31:0] q_exp [$];

   control_unit #(
      .IMEM_DEPTH(64),
      .DMEM_DEPTH(64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .wr2   (wr2)
   );

   initial clk = 1'b0;
   always #15 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Compare wr2 against the scoreboard, one commit per entry.
   task automatic drain(input string tag);
      logic [31:0] exp;
      while (q_exp.size() > 0) begin
         exp = q_exp.pop_front();
         check(tag, wr2, exp);
         next_cycle();
      end
   endtask

   initial begin
      logic [31:0] exp_regs [1:7];
      n_cmp = 0;
      n_err = 0;
      exp_regs = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd8, 32'd1, 32'd7};

      // Reset hold
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_wr2", wr2, 32'd0);
      check("reset_pc", dut.r_pc, 32'd0);

      // Program sequence
      reset = 1'b0;
      #1;
      foreach (exp_regs[k]) begin end
      q_exp.push_back(32'd5);
      q_exp.push_back(32'd3);
      q_exp.push_back(32'd8);
      q_exp.push_back(32'd2);
      q_exp.push_back(32'd0);
      q_exp.push_back(32'd8);
      q_exp.push_back(32'd1);
      q_exp.push_back(32'd7);
      q_exp.push_back(32'd0);
      q_exp.push_back(32'd0);
      q_exp.push_back(32'd0);
      drain("prog_wr2");

      check("loop_pc", dut.r_pc, 32'h20);
      for (int r = 1; r <= 7; r++) begin
         check($sformatf("x%0d", r), dut.r_regs[r], exp_regs[r]);
      end
      check("ram0", dut.r_dmem[0], 32'd8);

      // Long run: ~500 ns at 30 ns period
      for (int c = 0; c < 17; c++) begin
         check("long_known", {31'd0, $isunknown(wr2)}, 32'd0);
         check("long_pc_le_20", {31'd0, (dut.r_pc > 32'h20)}, 32'd0);
         q_exp.push_back(32'd0);
         drain("long_wr2");
      end
      check("x0_zero", dut.r_regs[0], 32'd0);

      // Reset mid-program at PC 0x0C
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      #1;
      q_exp.push_back(32'd5);
      q_exp.push_back(32'd3);
      q_exp.push_back(32'd8);
      drain("restart_wr2");
      check("mid_pc_0c", dut.r_pc, 32'h0C);
      check("mid_pre_wr2", wr2, 32'd2);
      reset = 1'b1;
      #1;
      check("mid_reset_wr2", wr2, 32'd0);
      next_cycle();
      check("mid_pc", dut.r_pc, 32'd0);
      check("mid_x1", dut.r_regs[1], 32'd0);
      check("mid_x3", dut.r_regs[3], 32'd0);
      check("mid_ram0", dut.r_dmem[0], 32'd0);
      check("mid_wr2", wr2, 32'd0);
      reset = 1'b0;
      #1;
      q_exp.push_back(32'd5);
      q_exp.push_back(32'd3);
      q_exp.push_back(32'd8);
      q_exp.push_back(32'd2);
      q_exp.push_back(32'd0);
      q_exp.push_back(32'd8);
      q_exp.push_back(32'd1);
      q_exp.push_back(32'd7);
      q_exp.push_back(32'd0);
      drain("rerun_wr2");
      check("rerun_ram0", dut.r_dmem[0], 32'd8);
      check("rerun_x5", dut.r_regs[5], 32'd8);
      check("rerun_x0", dut.r_regs[0], 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog so the bench always ends on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
